// File: rtl/la_cmd_pkg.sv
// ============================================================================
// Module   : la_cmd_pkg
// Brief    : Shared constants, opcodes, error codes and FSM states for la_cmd_rx.
//            FRAME_LEN depends on LA_CMD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package la_cmd_pkg;

`ifdef LA_CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    // Counter must reach FRAME_LEN+1 so that over-length frames stay distinguishable
    localparam int CNT_W = 4;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

    localparam logic [7:0] C_OP_CONFIG = 8'h01;
    localparam logic [7:0] C_OP_RUN    = 8'h02;
    localparam logic [7:0] C_OP_STOP   = 8'h03;

    localparam logic [2:0] C_ERR_NONE  = 3'd0;
    localparam logic [2:0] C_ERR_LEN   = 3'd1;
    localparam logic [2:0] C_ERR_SYNC  = 3'd2;
    localparam logic [2:0] C_ERR_CSUM  = 3'd3;
    localparam logic [2:0] C_ERR_OPC   = 3'd4;
    localparam logic [2:0] C_ERR_BUSY  = 3'd5;
    localparam logic [2:0] C_ERR_RANGE = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/la_cmd_rx_if.sv
// ============================================================================
// Module   : la_cmd_rx_if
// Brief    : Received-UDP-payload byte stream from the UDP stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface la_cmd_rx_if #(
    parameter int LEN_W = 16
);
    logic             udp_rec_data_valid;
    logic [7:0]       udp_rec_rdata;
    logic [LEN_W-1:0] udp_rec_data_length;

    modport master (
        output udp_rec_data_valid,
        output udp_rec_rdata,
        output udp_rec_data_length
    );

    modport slave (
        input  udp_rec_data_valid,
        input  udp_rec_rdata,
        input  udp_rec_data_length
    );
endinterface

`default_nettype wire

// File: rtl/la_cmd_frame_asm.sv
// ============================================================================
// Module   : la_cmd_frame_asm
// Brief    : Byte counter, frame buffer, running XOR and frame-end detect.
//            Checksum accumulator exists only with LA_CMD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_cmd_frame_asm
    import la_cmd_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              valid,
    input  wire              start,
    input  wire [7:0]        data,
    input  wire [LEN_W-1:0]  length,
    output logic [CNT_W-1:0] cnt,
    output logic [7:0]       frame [FRAME_LEN],
    output logic [LEN_W-1:0] frame_len,
    output logic             csum_ok,
    output logic             frame_end
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_prev_valid;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_frame [FRAME_LEN];
    logic             w_wr_en;
    logic [CNT_W-1:0] w_wr_idx;

    assign w_wr_idx = start ? '0 : r_cnt;
    assign w_wr_en  = valid & (start | (r_cnt < CNT_W'(FRAME_LEN)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_prev_valid <= 1'b0;
            r_len        <= '0;
        end else begin
            r_prev_valid <= valid;
            if (valid) begin
                r_len <= length;
                if (start) begin
                    r_cnt <= CNT_W'(1);
                end else if (r_cnt <= CNT_W'(FRAME_LEN)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < FRAME_LEN; i++) begin : g_byte
        always_ff @(posedge clk) begin
            if (rst) begin
                r_frame[i] <= '0;
            end else if (w_wr_en && (w_wr_idx == CNT_W'(i))) begin
                r_frame[i] <= data;
            end
        end
    end

`ifdef LA_CMD_CHECKSUM_EN
    // XOR over all stored bytes including B8 is zero for an intact frame
    logic [7:0] r_xor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xor <= '0;
        end else if (w_wr_en) begin
            r_xor <= start ? data : (r_xor ^ data);
        end
    end

    assign csum_ok = (r_xor == 8'h00);
`else
    assign csum_ok = 1'b1;
`endif

    assign cnt       = r_cnt;
    assign frame     = r_frame;
    assign frame_len = r_len;
    assign frame_end = r_prev_valid & ~valid;

endmodule

`default_nettype wire

// File: rtl/la_cmd_rx.sv
// ============================================================================
// Module   : la_cmd_rx
// Brief    : UDP command receiver: decodes, validates and applies host commands
//            to the analyser configuration/run control. Build option LA_CMD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_cmd_rx
    import la_cmd_pkg::*;
#(
    parameter int INPUT_WIDTH = 6,
    parameter int LEN_W       = 16
) (
    input  wire          rgmii_clk,
    input  wire          rst,
    la_cmd_rx_if.slave   udp,
    input  wire          ethernet_read_done,
    output logic [3:0]   sample_clk_cfg,
    output logic [31:0]  sample_num,
    output logic [1:0]   triger_type,
    output logic [2:0]   trigger_channel,
    output logic         sample_run,
    output logic         start_posedge,
    output logic         cmd_ok,
    output logic         cmd_err,
    output logic [2:0]   err_code
);

    localparam logic [31:0] C_INPUT_WIDTH = INPUT_WIDTH;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_frame_start;
    logic [CNT_W-1:0] w_cnt;
    logic [7:0]       w_frame [FRAME_LEN];
    logic [LEN_W-1:0] w_len;
    logic             w_csum_ok;
    logic             w_frame_end;

    logic [7:0]       w_opcode;
    logic [31:0]      w_num;
    logic [2:0]       w_trig_ch;
    logic             w_run_live;
    logic [2:0]       w_err_sel;

    logic [3:0]       w_clk_nxt;
    logic [31:0]      w_num_nxt;
    logic [1:0]       w_type_nxt;
    logic [2:0]       w_ch_nxt;
    logic             w_run_nxt;
    logic             w_start_nxt;
    logic             w_ok_nxt;
    logic             w_err_nxt;
    logic [2:0]       w_code_nxt;

    // A byte seen outside RECV always opens a new frame, including in CHECK
    assign w_frame_start = udp.udp_rec_data_valid & (r_state != ST_RECV);

    la_cmd_frame_asm #(
        .LEN_W (LEN_W)
    ) u_frame_asm (
        .clk       (rgmii_clk),
        .rst       (rst),
        .valid     (udp.udp_rec_data_valid),
        .start     (w_frame_start),
        .data      (udp.udp_rec_rdata),
        .length    (udp.udp_rec_data_length),
        .cnt       (w_cnt),
        .frame     (w_frame),
        .frame_len (w_len),
        .csum_ok   (w_csum_ok),
        .frame_end (w_frame_end)
    );

    assign w_opcode   = w_frame[1];
    assign w_num      = {w_frame[4], w_frame[5], w_frame[6], w_frame[7]};
    assign w_trig_ch  = w_frame[3][2:0];
    // Upload completion wins over a coincident command, so RUN is never BUSY then
    assign w_run_live = sample_run & ~ethernet_read_done;

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = sample_clk_cfg;
        w_num_nxt   = sample_num;
        w_type_nxt  = triger_type;
        w_ch_nxt    = trigger_channel;
        w_run_nxt   = w_run_live;
        w_start_nxt = 1'b0;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = err_code;
        w_err_sel   = C_ERR_NONE;

        if ((w_cnt != CNT_W'(FRAME_LEN)) || (w_len != LEN_W'(FRAME_LEN))) begin
            w_err_sel = C_ERR_LEN;
        end else if (w_frame[0] != C_SYNC_BYTE) begin
            w_err_sel = C_ERR_SYNC;
        end else if (!w_csum_ok) begin
            w_err_sel = C_ERR_CSUM;
        end else if ((w_opcode != C_OP_CONFIG) && (w_opcode != C_OP_RUN) &&
                     (w_opcode != C_OP_STOP)) begin
            w_err_sel = C_ERR_OPC;
        end else if ((w_opcode != C_OP_STOP) && w_run_live) begin
            w_err_sel = C_ERR_BUSY;
        end else if ((w_opcode == C_OP_CONFIG) &&
                     ((w_num == 32'd0) || ({29'd0, w_trig_ch} >= C_INPUT_WIDTH))) begin
            w_err_sel = C_ERR_RANGE;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (udp.udp_rec_data_valid) begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_frame_end) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt = udp.udp_rec_data_valid ? ST_RECV : ST_IDLE;
                w_code_nxt  = w_err_sel;
                if (w_err_sel != C_ERR_NONE) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_ok_nxt = 1'b1;
                    if (w_opcode == C_OP_CONFIG) begin
                        w_clk_nxt  = w_frame[2][7:4];
                        w_type_nxt = w_frame[2][3:2];
                        w_ch_nxt   = w_trig_ch;
                        w_num_nxt  = w_num;
                    end else if (w_opcode == C_OP_RUN) begin
                        w_run_nxt   = 1'b1;
                        w_start_nxt = 1'b1;
                    end else begin
                        w_run_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            sample_clk_cfg  <= '0;
            sample_num      <= '0;
            triger_type     <= '0;
            trigger_channel <= '0;
            sample_run      <= 1'b0;
            start_posedge   <= 1'b0;
            cmd_ok          <= 1'b0;
            cmd_err         <= 1'b0;
            err_code        <= '0;
        end else begin
            sample_clk_cfg  <= w_clk_nxt;
            sample_num      <= w_num_nxt;
            triger_type     <= w_type_nxt;
            trigger_channel <= w_ch_nxt;
            sample_run      <= w_run_nxt;
            start_posedge   <= w_start_nxt;
            cmd_ok          <= w_ok_nxt;
            cmd_err         <= w_err_nxt;
            err_code        <= w_code_nxt;
        end
    end

endmodule

`default_nettype wire
